// File: rtl/syscall_print_ctrl.sv
// syscall_print_ctrl
// Services the print-string system call. While a request is active the
// controller stalls the CPU, takes over the data-memory port, walks a
// null-terminated string one word at a time and hands each byte to a
// console sink through a valid/ready handshake. When idle, the data-memory
// port is a transparent pass-through of the CPU's own memory accesses.

module syscall_print_ctrl #(
    parameter int          MAX_LEN    = 256,
    parameter logic [31:0] PRINT_CODE = 32'd4
) (
    input  logic        clk,
    input  logic        reset,

    // syscall request from the CPU decode stage
    input  logic        syscall,
    input  logic [31:0] v0,
    input  logic [31:0] a0,
    output logic        stall,

    // CPU side of the data-memory port
    input  logic        cpu_memWrite,
    input  logic        cpu_memRead,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_writeData,
    output logic [31:0] cpu_readData,

    // data-memory side (memory indexes words by address>>2)
    output logic        mem_memWrite,
    output logic        mem_memRead,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writeData,
    input  logic [31:0] mem_readData,

    // console sink
    output logic        char_valid,
    output logic [7:0]  char_data,
    input  logic        char_ready,

    output logic        done
);

    // The count must be able to hold MAX_LEN itself, hence the +1.
    localparam int            CW      = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EMIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state;
    logic [31:0]   addr;       // byte address of the next character
    logic [CW-1:0] count;      // characters emitted for this request
    logic [31:0]   word_reg;   // word currently being walked

    logic          accept;     // a print request is taken this cycle
    logic          in_print;   // controller owns the memory port
    logic [7:0]    cur_byte;   // byte under addr within word_reg
    logic          fire;       // sink takes a character this cycle
    logic [31:0]   addr_next;
    logic [CW-1:0] count_next;

    assign accept     = (state == S_IDLE) && syscall && (v0 == PRINT_CODE);
    assign in_print   = (state == S_FETCH) || (state == S_EMIT);
    assign fire       = char_valid && char_ready;
    assign addr_next  = addr + 32'd1;
    assign count_next = count + CW'(1);

    // Big-endian byte lane select: offset 0 is the most significant byte.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch so
        // that no path leaves it unassigned; an unassigned path infers a latch.
        cur_byte = 8'h00;
        case (addr[1:0])
            2'd0:    cur_byte = word_reg[31:24];
            2'd1:    cur_byte = word_reg[23:16];
            2'd2:    cur_byte = word_reg[15:8];
            default: cur_byte = word_reg[7:0];
        endcase
    end

    // Character output is decoded from the state and the latched word, so
    // it stays stable while the sink back-pressures and drops the instant an
    // asynchronous reset returns the state to IDLE.
    always_comb begin
        char_valid = 1'b0;
        char_data  = 8'h00;
        if ((state == S_EMIT) && (cur_byte != 8'h00)) begin
            char_valid = 1'b1;
            char_data  = cur_byte;
        end
    end

    // The stall must rise in the same cycle the syscall is decoded so the
    // pipeline never advances past it, hence the combinational accept term.
    always_comb begin
        stall = accept || in_print;
    end

    // Memory port ownership: pass-through outside a print, controller-owned
    // reads (never writes) while walking the string.
    always_comb begin
        mem_memWrite  = cpu_memWrite;
        mem_memRead   = cpu_memRead;
        mem_address   = cpu_address;
        mem_writeData = cpu_writeData;
        if (in_print) begin
            mem_memWrite = 1'b0;
            mem_memRead  = (state == S_FETCH);
            mem_address  = {addr[31:2], 2'b00};
        end
    end

    // Load data always flows straight back to the CPU.
    always_comb begin
        cpu_readData = mem_readData;
    end

    // Print sequencer: accepts a request, fetches words, emits bytes until a
    // NUL or the length guard, then pulses done for one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            addr     <= 32'h0;
            count    <= '0;
            word_reg <= 32'h0;
            done     <= 1'b0;
        end else begin
            // NOTE: sequential state is always updated with non-blocking
            // assignments so every flop samples the pre-edge values; blocking
            // assignments here would make results depend on statement order.
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        addr  <= a0;
                        count <= '0;
                        state <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    word_reg <= mem_readData;
                    state    <= S_EMIT;
                end

                S_EMIT: begin
                    if (cur_byte == 8'h00) begin
                        // terminator reached: nothing is emitted for it
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else if (fire) begin
                        addr  <= addr_next;
                        count <= count_next;
                        if (count_next == MAX_CNT) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else if (addr_next[1:0] == 2'b00) begin
                            state <= S_FETCH;
                        end
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/syscall_print_ctrl.md
SYSCALL_PRINT_CTRL -- requirements
Module: syscall_print_ctrl

Interface
REQ-001 Parameter: MAX_LEN, default 256, maximum characters emitted per print request (runaway guard).
REQ-002 Parameter: PRINT_CODE, default 32'd4, v0 value selecting print-string.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 syscall  input  1  CPU decoded a syscall this cycle.
REQ-006 v0  input  32  syscall service code.
REQ-007 a0  input  32  byte address of null-terminated string.
REQ-008 stall  output  1  freezes CPU pipeline while high.
REQ-009 cpu_memWrite, cpu_memRead  input  1 each  CPU data-memory strobes.
REQ-010 cpu_address, cpu_writeData  input  32 each  CPU address/store data.
REQ-011 cpu_readData  output  32  load data returned to CPU.
REQ-012 mem_memWrite, mem_memRead  output  1 each  strobes to data memory.
REQ-013 mem_address, mem_writeData  output  32 each  to data memory (memory indexes by address>>2).
REQ-014 mem_readData  input  32  combinational read data from data memory.
REQ-015 char_valid  output  1  character available to console sink.
REQ-016 char_data  output  8  character byte.
REQ-017 char_ready  input  1  console sink accepts character.
REQ-018 done  output  1  one-cycle pulse at end of a print request.

Function
REQ-019 FSM states SHALL be IDLE, FETCH, EMIT, DONE.
REQ-020 IDLE: syscall=1 and v0==PRINT_CODE -> latch addr=a0, count=0, go FETCH; any other v0 ignored, stay IDLE.
REQ-021 stall SHALL be high combinationally in IDLE on an accepted request, and high throughout FETCH and EMIT; low in IDLE otherwise and in DONE.
REQ-022 FETCH: mem_memRead=1, mem_address={addr[31:2],2'b00}, mem_memWrite=0; word_reg<=mem_readData at posedge; go EMIT (one cycle).
REQ-023 Byte select big-endian: addr[1:0]=0 -> word_reg[31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
REQ-024 EMIT, selected byte==8'h00: char_valid=0, go DONE, no character emitted.
REQ-025 EMIT, nonzero byte: char_valid=1, char_data=byte; char_data SHALL hold stable while char_valid=1 and char_ready=0.
REQ-026 EMIT handshake char_valid&char_ready: addr<=addr+1 (32-bit wrap, 0xFFFFFFFF->0), count<=count+1; if count+1==MAX_LEN go DONE; else if (addr+1)[1:0]==0 go FETCH; else stay EMIT.
REQ-027 Max throughput one character per cycle within a word; one extra FETCH cycle per word boundary.
REQ-028 DONE: done=1 for exactly one cycle, go IDLE; a new request is accepted no earlier than the following IDLE cycle.
REQ-029 IDLE and DONE: mem_* SHALL equal cpu_* (pass-through); FETCH/EMIT: mem_memWrite=0, mem_memRead driven by controller, CPU strobes ignored.
REQ-030 cpu_readData SHALL equal mem_readData in all states.
REQ-031 syscall asserted outside IDLE SHALL be ignored.
REQ-032 char_valid=0 outside EMIT.

Reset
REQ-033 reset=1 SHALL force state=IDLE, addr=0, count=0, word_reg=0 immediately, without waiting for clk.
REQ-034 During reset: stall=0, char_valid=0, char_data=0, done=0, mem_* pass-through of cpu_*.
REQ-035 Reset mid-EMIT SHALL drop char_valid asynchronously; no done pulse is generated for the aborted request.

Verification
REQ-036 Memory word 0x10010000="Hi\0\0" (0x48690000); syscall, v0=4, a0=0x10010000, char_ready=1 -> chars 0x48,0x69 on consecutive cycles, then done pulse; stall high FETCH through EMIT, low in DONE.
REQ-037 a0=0x10010003, word@0x10010000=0x00000041, word@0x10010004=0x42000000 -> 'A', FETCH cycle, then 0x42, then done (no NUL emitted).
REQ-038 char_ready held low 5 cycles on first char -> char_valid and char_data stable 5 cycles, addr unchanged, no extra FETCH.
REQ-039 MAX_LEN=4, string of 10 nonzero bytes -> exactly 4 chars emitted, then done; syscall with v0=1 -> no stall, no chars.
REQ-040 Reset asserted during second char of a 6-char string -> char_valid and stall low same cycle, state IDLE, no done; new request afterwards prints full string.
REQ-041 In IDLE, cpu_memWrite=1, cpu_address=0x7FFFFFFC, cpu_writeData=0xDEADBEEF -> mem ports mirror; during EMIT, cpu_memWrite=1 -> mem_memWrite=0.
